// File: rtl/nco_quarter_wave.sv
// Quarter-wave NCO: phase accumulator + shared folded sine ROM driving sin/cos for carrier wipe-off.
// Latency 3 cycles en->out_valid, one sample per cycle, no backpressure (en gaps become out_valid gaps).
module nco_quarter_wave #(
   parameter int PHASE_W = 32,
   parameter int LUT_AW  = 8,
   parameter int AMP_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     fcw_load,
   input  logic [PHASE_W-1:0]       fcw_in,
   input  logic [PHASE_W-1:0]       phase_off,
   input  logic                     phase_clr,
   output logic signed [AMP_W-1:0]  sin_out,
   output logic signed [AMP_W-1:0]  cos_out,
   output logic                     out_valid,
   output logic                     wrap_out
);

   localparam int DEPTH = 2**LUT_AW;
   localparam int A     = 2**(AMP_W-1) - 1;
   localparam int PH    = LUT_AW + 2;

   // Table built at elaboration from a Taylor series (error far below one LSB over [0, pi/2)).
   function automatic logic [AMP_W-2:0] lut_val(input int i);
      real x, x2, term, s;
      x    = (real'(i) + 0.5) * 3.14159265358979323846 / (2.0 * real'(DEPTH));
      x2   = x * x;
      term = x;
      s    = x;
      for (int n = 1; n < 10; n++) begin
         term = -term * x2 / real'((2*n) * (2*n + 1));
         s    = s + term;
      end
      return (AMP_W-1)'($rtoi(s * real'(A) + 0.5));
   endfunction

   logic [AMP_W-2:0] rom [DEPTH];
   for (genvar g = 0; g < DEPTH; g++) begin : g_rom
      assign rom[g] = lut_val(g);
   end

   logic [PHASE_W-1:0] acc, fcw, acc_eff;
   logic [PHASE_W:0]   acc_sum;

   assign acc_eff = phase_clr ? '0 : acc;
   assign acc_sum = {1'b0, acc_eff} + {1'b0, fcw};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         fcw <= '0;
      end else begin
         if (en)
            acc <= acc_sum[PHASE_W-1:0];
         else if (phase_clr)
            acc <= '0;
         if (fcw_load)
            fcw <= fcw_in;
      end
   end

   // S1: only quadrant + index bits of the sample phase are kept; the rest is truncated.
   logic          s1_vld, s1_wrap;
   logic [PH-1:0] s1_ph;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld  <= 1'b0;
         s1_wrap <= 1'b0;
         s1_ph   <= '0;
      end else begin
         s1_vld  <= en;
         s1_wrap <= en & acc_sum[PHASE_W];
         if (en)
            s1_ph <= PH'((acc_eff + phase_off) >> (PHASE_W - PH));
      end
   end

   logic [1:0]        q_s, q_c;
   logic [LUT_AW-1:0] k, addr_s, addr_c;

   // Odd quadrants read the table mirrored: DEPTH-1-k is the bitwise inverse of k.
   assign q_s    = s1_ph[PH-1 -: 2];
   assign q_c    = q_s + 2'd1;
   assign k      = s1_ph[LUT_AW-1:0];
   assign addr_s = q_s[0] ? ~k : k;
   assign addr_c = q_c[0] ? ~k : k;

   logic             s2_vld, s2_wrap, s2_neg_s, s2_neg_c;
   logic [AMP_W-2:0] s2_mag_s, s2_mag_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_vld   <= 1'b0;
         s2_wrap  <= 1'b0;
         s2_neg_s <= 1'b0;
         s2_neg_c <= 1'b0;
         s2_mag_s <= '0;
         s2_mag_c <= '0;
      end else begin
         s2_vld  <= s1_vld;
         s2_wrap <= s1_wrap;
         if (s1_vld) begin
            s2_neg_s <= q_s[1];
            s2_neg_c <= q_c[1];
            s2_mag_s <= rom[addr_s];
            s2_mag_c <= rom[addr_c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sin_out   <= '0;
         cos_out   <= '0;
         out_valid <= 1'b0;
         wrap_out  <= 1'b0;
      end else begin
         out_valid <= s2_vld;
         wrap_out  <= s2_vld & s2_wrap;
         if (s2_vld) begin
            sin_out <= s2_neg_s ? -{1'b0, s2_mag_s} : {1'b0, s2_mag_s};
            cos_out <= s2_neg_c ? -{1'b0, s2_mag_c} : {1'b0, s2_mag_c};
         end
      end
   end

endmodule

// File: tb/tb_nco_quarter_wave.sv
// Directed bench for nco_quarter_wave with hand-computed ROM values:
// LUT[0]=101 LUT[1]=302 LUT[2]=503 LUT[3]=704 LUT[254]=32766 LUT[255]=32767.
module tb_nco_quarter_wave;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en, fcw_load, phase_clr;
   logic [31:0]        fcw_in, phase_off;
   logic signed [15:0] sin_out, cos_out;
   logic               out_valid, wrap_out;

   int errors = 0;
   int checks = 0;

   nco_quarter_wave #(.PHASE_W(32), .LUT_AW(8), .AMP_W(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .fcw_load  (fcw_load),
      .fcw_in    (fcw_in),
      .phase_off (phase_off),
      .phase_clr (phase_clr),
      .sin_out   (sin_out),
      .cos_out   (cos_out),
      .out_valid (out_valid),
      .wrap_out  (wrap_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   int exp_s [4] = '{101, 32767, -101, -32767};
   int exp_c [4] = '{32767, -101, -32767, 101};
   int pat_en  [10] = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 0};
   int pat_sin [8]  = '{101, 101, 302, 503, 503, 503, 704, 704};
   int wraps, bad_wrap, bad_vld;

   initial begin
      rst_n = 1'b0; en = 1'b0; fcw_load = 1'b0; phase_clr = 1'b0;
      fcw_in = '0; phase_off = '0;
      repeat (2) step();
      chk("rst_sin", sin_out, 0);
      chk("rst_cos", cos_out, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_wrap", wrap_out, 0);
      rst_n = 1'b1;
      step();

      // Sweep at fcw=2^22: 1024 samples per cycle.
      fcw_load = 1'b1; fcw_in = 32'h0040_0000;
      step();
      fcw_load = 1'b0; en = 1'b1;
      step(); step();
      chk("lat_vld_early", out_valid, 0);
      step();
      wraps = 0; bad_wrap = 0; bad_vld = 0;
      for (int n = 0; n < 4096; n++) begin
         if (n % 256 == 0 && n < 1024) begin
            chk("sweep_sin", sin_out, exp_s[n/256]);
            chk("sweep_cos", cos_out, exp_c[n/256]);
         end
         if (n == 1) begin
            chk("sweep_sin1", sin_out, 302);
            chk("sweep_cos1", cos_out, 32766);
         end
         if (out_valid !== 1'b1) bad_vld++;
         if (wrap_out === 1'b1) wraps++;
         if (wrap_out !== ((n % 1024) == 1023)) bad_wrap++;
         step();
      end
      chk("sweep_vld_gaps", bad_vld, 0);
      chk("wrap_count", wraps, 4);
      chk("wrap_position", bad_wrap, 0);
      en = 1'b0;
      repeat (3) step();
      chk("drain_vld", out_valid, 0);

      // Static phase: fcw=0, offset steps a quarter then a half cycle.
      fcw_load = 1'b1; fcw_in = '0; phase_clr = 1'b1; phase_off = 32'h4000_0000;
      step();
      fcw_load = 1'b0; phase_clr = 1'b0; en = 1'b1;
      repeat (3) step();
      chk("off90_vld", out_valid, 1);
      chk("off90_sin", sin_out, 32767);
      chk("off90_cos", cos_out, -101);
      step();
      chk("off90_sin_hold", sin_out, 32767);
      phase_off = 32'h8000_0000;
      step();
      chk("off180_inflight1", sin_out, 32767);
      step();
      chk("off180_inflight2", sin_out, 32767);
      step();
      chk("off180_sin", sin_out, -101);
      chk("off180_cos", cos_out, -32767);

      // phase_clr with en on sample 10, simultaneous fcw reload to 2^23.
      en = 1'b0; phase_off = '0; fcw_load = 1'b1; fcw_in = 32'h0040_0000; phase_clr = 1'b1;
      step();
      fcw_load = 1'b0; phase_clr = 1'b0; en = 1'b1;
      repeat (10) step();
      phase_clr = 1'b1; fcw_load = 1'b1; fcw_in = 32'h0080_0000;
      step();
      phase_clr = 1'b0; fcw_load = 1'b0;
      step(); step();
      chk("clr_s10_sin", sin_out, 101);
      chk("clr_s10_cos", cos_out, 32767);
      step();
      chk("clr_s11_sin", sin_out, 302);
      chk("clr_s11_cos", cos_out, 32766);
      step();
      chk("clr_s12_sin", sin_out, 704);

      // en gaps: valid pattern follows en by 3 cycles, outputs hold, acc does not advance.
      en = 1'b0; fcw_load = 1'b1; fcw_in = 32'h0040_0000; phase_clr = 1'b1;
      step();
      fcw_load = 1'b0; phase_clr = 1'b0;
      for (int i = 0; i < 10; i++) begin
         en = pat_en[i][0];
         step();
         if (i >= 2) begin
            chk("gap_vld", out_valid, pat_en[i-2]);
            chk("gap_sin", sin_out, pat_sin[i-2]);
            chk("gap_wrap", wrap_out, 0);
         end
      end

      // Asynchronous reset mid-stream, then restart with fcw cleared.
      fcw_load = 1'b1; fcw_in = 32'h0040_0000; phase_clr = 1'b1;
      step();
      fcw_load = 1'b0; phase_clr = 1'b0; en = 1'b1;
      repeat (5) step();
      chk("pre_arst_vld", out_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_sin", sin_out, 0);
      chk("arst_cos", cos_out, 0);
      chk("arst_vld", out_valid, 0);
      chk("arst_wrap", wrap_out, 0);
      step(); step();
      rst_n = 1'b1;
      step(); step();
      chk("post_rst_vld_early", out_valid, 0);
      step();
      chk("post_rst_vld", out_valid, 1);
      chk("post_rst_sin", sin_out, 101);
      chk("post_rst_cos", cos_out, 32767);
      step();
      chk("post_rst_fcw0_sin", sin_out, 101);
      en = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
